// File: rtl/irq_pkg.sv
// Shared constants and FSM state type for the interrupt pending controller.
package irq_pkg;
  localparam int N   = 3;
  localparam int IDW = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    HOLDOFF = 2'd2
  } state_e;
endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector: rise_o is high for the cycle in which req_i
// goes 0->1.
module rise_detect #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] req_i,
  output logic [W-1:0] rise_o
);
  logic [W-1:0] req_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) req_q <= '0;
    else     req_q <= req_i;
  end

  // Reset leaves the history low, so a line already high at release counts as an edge.
  assign rise_o = req_i & ~req_q;
endmodule

// File: rtl/irq_pending_ctrl.sv
// Rising-edge request capture, masked presentation to the downstream priority
// encoder, and the valid/ack service sequencer that clears the serviced bit.
//
// state   | meaning
// IDLE    | waiting for a valid in-range encoder index
// PRESENT | irq_valid high, irq_id held until irq_ack
// HOLDOFF | one dead cycle so the cleared bit leaves the encoder
module irq_pending_ctrl
  import irq_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_in,
  input  logic [N-1:0]   mask_in,
  output logic [N-1:0]   pend_to_enc,
  input  logic [IDW-1:0] enc_idx,
  input  logic           enc_valid,
  output logic           irq_valid,
  output logic [IDW-1:0] irq_id,
  input  logic           irq_ack,
  output logic [N-1:0]   pending,
  output logic [N-1:0]   overflow,
  input  logic           ovf_clr
);
  state_e         state_q;
  logic           irq_valid_q;
  logic [IDW-1:0] irq_id_q;
  logic [N-1:0]   pending_q, pending_d;
  logic [N-1:0]   overflow_q, overflow_d;
  logic [N-1:0]   rise;
  logic [N-1:0]   clr_vec;
  logic           ack_acc;

  rise_detect #(.W(N)) u_rise (
    .clk    (clk),
    .rst    (rst),
    .req_i  (req_in),
    .rise_o (rise)
  );

  assign ack_acc = (state_q == PRESENT) && irq_ack;

  // Set beats clear; a re-arm on the bit being serviced is not an overflow.
  always_comb begin
    clr_vec    = ack_acc ? (N'(1) << irq_id_q) : '0;
    pending_d  = (pending_q & ~clr_vec) | rise;
    overflow_d = (overflow_q & ~{N{ovf_clr}}) | (rise & pending_q & ~clr_vec);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q  <= '0;
      overflow_q <= '0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      irq_valid_q <= 1'b0;
      irq_id_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enc_valid && (enc_idx < IDW'(N))) begin
            irq_id_q    <= enc_idx;
            irq_valid_q <= 1'b1;
            state_q     <= PRESENT;
          end
        end
        PRESENT: begin
          if (irq_ack) begin
            irq_valid_q <= 1'b0;
            state_q     <= HOLDOFF;
          end
        end
        HOLDOFF: begin
          irq_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: begin
          irq_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign pend_to_enc = pending_q & ~mask_in;
  assign pending     = pending_q;
  assign overflow    = overflow_q;
  assign irq_valid   = irq_valid_q;
  assign irq_id      = irq_id_q;
endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Bench for irq_pending_ctrl with a behavioural priority encoder in front of it.
module tb_irq_pending_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] req_in = '0, mask_in = '0;
  logic [2:0] pend_to_enc, pending, overflow;
  logic [1:0] enc_idx, irq_id;
  logic       enc_valid, irq_valid;
  logic       irq_ack = 1'b0, ovf_clr = 1'b0;
  logic       force_bad = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  irq_pending_ctrl dut (
    .clk(clk), .rst(rst), .req_in(req_in), .mask_in(mask_in),
    .pend_to_enc(pend_to_enc), .enc_idx(enc_idx), .enc_valid(enc_valid),
    .irq_valid(irq_valid), .irq_id(irq_id), .irq_ack(irq_ack),
    .pending(pending), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  // Downstream encoder: lowest set bit wins; force_bad injects an out-of-range index.
  always_comb begin
    enc_valid = 1'b0;
    enc_idx   = 2'd0;
    if (force_bad) begin
      enc_valid = 1'b1;
      enc_idx   = 2'd3;
    end else begin
      for (int i = 2; i >= 0; i--)
        if (pend_to_enc[i]) begin
          enc_valid = 1'b1;
          enc_idx   = 2'(i);
        end
    end
  end

  // Reference model: per-line bits plus "presenting" and "cooling down" flags.
  bit m_prev[3], m_pend[3], m_ovf[3];
  bit m_show, m_cool;
  int m_id;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin m_prev[i] = 0; m_pend[i] = 0; m_ovf[i] = 0; end
    m_show = 0; m_cool = 0; m_id = 0;
  endtask

  task automatic model_edge();
    bit served, rise;
    int pick;
    pick = -1;
    if (!m_show && !m_cool && !force_bad)
      for (int i = 2; i >= 0; i--)
        if (m_pend[i] && !mask_in[i]) pick = i;
    for (int i = 0; i < 3; i++) begin
      rise   = req_in[i] && !m_prev[i];
      served = m_show && irq_ack && (m_id == i);
      if (rise && m_pend[i] && !served) m_ovf[i] = 1;
      else if (ovf_clr)                 m_ovf[i] = 0;
      m_pend[i] = rise || (m_pend[i] && !served);
      m_prev[i] = req_in[i];
    end
    if (m_show) begin
      if (irq_ack) begin m_show = 0; m_cool = 1; end
    end else if (m_cool) begin
      m_cool = 0;
    end else if (pick >= 0) begin
      m_show = 1; m_id = pick;
    end
  endtask

  function automatic int pack(input bit b[3]);
    return b[0] + 2 * b[1] + 4 * b[2];
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [2:0] r, input logic [2:0] m, input logic a,
                      input logic oc, input logic bad);
    req_in = r; mask_in = m; irq_ack = a; ovf_clr = oc; force_bad = bad;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("m_valid", int'(irq_valid), int'(m_show));
    if (m_show) chk("m_id", int'(irq_id), m_id);
    chk("m_pend", int'(pending), pack(m_pend));
    chk("m_ovf", int'(overflow), pack(m_ovf));
    chk("m_p2e", int'(pend_to_enc), pack(m_pend) & ~int'(mask_in));
  endtask

  typedef struct {
    logic [2:0] req, mask;
    logic       ack, oc, v;
    logic [1:0] id;
    logic [2:0] pend, ovf;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [2:0] r, m, input logic a, oc, v,
                     input logic [1:0] id, input logic [2:0] p, o);
    vec_t t;
    t = '{req: r, mask: m, ack: a, oc: oc, v: v, id: id, pend: p, ovf: o};
    tbl.push_back(t);
  endtask

  initial begin
    int guard;
    model_reset();
    // req mask ack clr | valid id pend ovf
    add(3'd0, 3'd0, 0, 0, 0, 2'd0, 3'd0, 3'd0);
    add(3'd2, 3'd0, 0, 0, 0, 2'd0, 3'd2, 3'd0);  // single line
    add(3'd2, 3'd0, 0, 0, 1, 2'd1, 3'd2, 3'd0);
    add(3'd2, 3'd0, 1, 0, 0, 2'd1, 3'd0, 3'd0);
    add(3'd0, 3'd0, 0, 0, 0, 2'd1, 3'd0, 3'd0);
    add(3'd5, 3'd0, 0, 0, 0, 2'd1, 3'd5, 3'd0);  // priority
    add(3'd5, 3'd0, 0, 0, 1, 2'd0, 3'd5, 3'd0);
    add(3'd5, 3'd0, 1, 0, 0, 2'd0, 3'd4, 3'd0);
    add(3'd0, 3'd0, 1, 0, 0, 2'd0, 3'd4, 3'd0);  // ack in HOLDOFF ignored
    add(3'd0, 3'd0, 0, 0, 1, 2'd2, 3'd4, 3'd0);
    add(3'd0, 3'd0, 1, 0, 0, 2'd2, 3'd0, 3'd0);
    add(3'd0, 3'd0, 0, 0, 0, 2'd2, 3'd0, 3'd0);
    add(3'd3, 3'd1, 0, 0, 0, 2'd2, 3'd3, 3'd0);  // mask
    add(3'd3, 3'd1, 0, 0, 1, 2'd1, 3'd3, 3'd0);
    add(3'd3, 3'd1, 1, 0, 0, 2'd1, 3'd1, 3'd0);
    add(3'd3, 3'd0, 0, 0, 0, 2'd1, 3'd1, 3'd0);
    add(3'd3, 3'd0, 0, 0, 1, 2'd0, 3'd1, 3'd0);
    add(3'd3, 3'd0, 1, 0, 0, 2'd0, 3'd0, 3'd0);
    add(3'd0, 3'd0, 0, 0, 0, 2'd0, 3'd0, 3'd0);
    add(3'd4, 3'd0, 0, 0, 0, 2'd0, 3'd4, 3'd0);  // overflow
    add(3'd0, 3'd0, 0, 0, 1, 2'd2, 3'd4, 3'd0);
    add(3'd4, 3'd0, 0, 0, 1, 2'd2, 3'd4, 3'd4);
    add(3'd0, 3'd0, 0, 0, 1, 2'd2, 3'd4, 3'd4);
    add(3'd4, 3'd0, 0, 0, 1, 2'd2, 3'd4, 3'd4);
    add(3'd0, 3'd0, 0, 1, 1, 2'd2, 3'd4, 3'd0);
    add(3'd0, 3'd0, 1, 0, 0, 2'd2, 3'd0, 3'd0);
    add(3'd0, 3'd0, 0, 0, 0, 2'd2, 3'd0, 3'd0);
    add(3'd1, 3'd0, 0, 0, 0, 2'd2, 3'd1, 3'd0);  // set wins over clear
    add(3'd0, 3'd0, 0, 0, 1, 2'd0, 3'd1, 3'd0);
    add(3'd1, 3'd0, 1, 0, 0, 2'd0, 3'd1, 3'd0);
    add(3'd1, 3'd0, 0, 0, 0, 2'd0, 3'd1, 3'd0);
    add(3'd0, 3'd0, 0, 0, 1, 2'd0, 3'd1, 3'd0);
    add(3'd0, 3'd0, 1, 0, 0, 2'd0, 3'd0, 3'd0);
    add(3'd0, 3'd0, 0, 0, 0, 2'd0, 3'd0, 3'd0);
    add(3'd1, 3'd7, 1, 0, 0, 2'd0, 3'd1, 3'd0);  // ack in IDLE ignored
    add(3'd1, 3'd7, 1, 0, 0, 2'd0, 3'd1, 3'd0);
    add(3'd0, 3'd7, 0, 0, 0, 2'd0, 3'd1, 3'd0);

    repeat (2) @(negedge clk);
    chk("rst_valid", int'(irq_valid), 0);
    chk("rst_id", int'(irq_id), 0);
    chk("rst_pend", int'(pending), 0);
    chk("rst_ovf", int'(overflow), 0);
    rst = 1'b0;

    foreach (tbl[k]) begin
      step(tbl[k].req, tbl[k].mask, tbl[k].ack, tbl[k].oc, 1'b0);
      chk($sformatf("tbl%0d_valid", k), int'(irq_valid), int'(tbl[k].v));
      chk($sformatf("tbl%0d_id", k), int'(irq_id), int'(tbl[k].id));
      chk($sformatf("tbl%0d_pend", k), int'(pending), int'(tbl[k].pend));
      chk($sformatf("tbl%0d_ovf", k), int'(overflow), int'(tbl[k].ovf));
    end

    // Out-of-range encoder index must not start a presentation.
    step(3'd0, 3'd7, 0, 1, 1);
    step(3'd0, 3'd7, 0, 0, 1);
    chk("bad_idx_valid", int'(irq_valid), 0);

    for (int c = 0; c < 400; c++)
      step(3'($urandom), ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'd0,
           1'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 9) == 0);

    // Reset in the middle of a presentation.
    guard = 0;
    while (!irq_valid && guard < 10) begin
      step(3'd0, 3'd0, 0, 0, 0);
      step(3'd1, 3'd0, 0, 0, 0);
      guard++;
    end
    chk("reach_present", int'(irq_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", int'(irq_valid), 0);
    chk("midrst_pend", int'(pending), 0);
    chk("midrst_ovf", int'(overflow), 0);
    model_reset();
    req_in = 3'd2; irq_ack = 1'b1; mask_in = 3'd0; ovf_clr = 1'b0; force_bad = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    step(3'd2, 3'd0, 1, 0, 0);
    chk("post_rst_valid", int'(irq_valid), 0);
    chk("post_rst_pend", int'(pending), 2);
    step(3'd2, 3'd0, 0, 0, 0);
    chk("post_rst_present", int'(irq_valid), 1);
    chk("post_rst_id", int'(irq_id), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
